// File: rtl/add_arbiter_if.sv
// Request/result bundle for add_arbiter: request and operand inputs, one-hot grant, valid/ready result.
// Grant is combinational. The result register is released by res_ready.
interface add_arbiter_if;
   logic [3:0] req;
   logic [7:0] operand;
   logic [3:0] gnt;
   logic       res_valid;
   logic [3:0] res_data;
   logic [1:0] res_id;
   logic       res_ready;
   logic       busy;
   logic [7:0] served_cnt;

   modport master (
      output req, operand, res_ready,
      input  gnt, res_valid, res_data, res_id, busy, served_cnt
   );

   modport slave (
      input  req, operand, res_ready,
      output gnt, res_valid, res_data, res_id, busy, served_cnt
   );
endinterface

// File: rtl/add_arbiter.sv
// Round-robin arbiter that adds OFFSET to the winning operand. The grant is combinational, and the result follows one cycle later.
// Backpressure: while a result is unconsumed (res_ready low), grants stop. Consume and grant can happen in the same cycle.
module add_arbiter #(
   parameter int         N_REQ  = 4,
   parameter logic [2:0] OFFSET = 3'b111
) (
   input  logic           clk,
   input  logic           rst,
   add_arbiter_if.slave   bus
);
   typedef enum logic {IDLE, HOLD} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [1:0]         r_ptr;
   logic               r_res_valid;
   logic [3:0]         r_res_data;
   logic [1:0]         r_res_id;
   logic [7:0]         r_served_cnt;

   logic [N_REQ-1:0]   w_rot;
   logic [1:0]         w_off;
   logic [1:0]         w_winner;
   logic               w_opp;
   logic               w_grant;
   logic               w_consume;
   logic [1:0]         w_operand;
   logic [3:0]         w_sum;

   // Rotate so that bit 0 is the requester at the pointer. The first set bit then wins.
   always_comb begin
      w_rot = bus.req;
      case (r_ptr)
         2'd0: w_rot = bus.req;
         2'd1: w_rot = {bus.req[0],   bus.req[3:1]};
         2'd2: w_rot = {bus.req[1:0], bus.req[3:2]};
         2'd3: w_rot = {bus.req[2:0], bus.req[3]};
         default: w_rot = bus.req;
      endcase
   end

   always_comb begin
      w_off = 2'd0;
      if (w_rot[0])      w_off = 2'd0;
      else if (w_rot[1]) w_off = 2'd1;
      else if (w_rot[2]) w_off = 2'd2;
      else if (w_rot[3]) w_off = 2'd3;
   end

   assign w_winner  = r_ptr + w_off;
   assign w_opp     = (r_state == IDLE) || bus.res_ready;
   assign w_grant   = !rst && w_opp && (|bus.req);
   assign w_consume = (r_state == HOLD) && r_res_valid && bus.res_ready;
   assign w_operand = bus.operand[{w_winner, 1'b0} +: 2];
   assign w_sum     = {2'b00, w_operand} + {1'b0, OFFSET};

   always_comb begin
      w_state_nxt = r_state;
      bus.gnt     = 4'b0000;
      if (w_grant) begin
         w_state_nxt = HOLD;
         bus.gnt     = 4'b0001 << w_winner;
      end else if (w_consume) begin
         w_state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_ptr        <= 2'd0;
         r_res_valid  <= 1'b0;
         r_res_data   <= 4'd0;
         r_res_id     <= 2'd0;
         r_served_cnt <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant) begin
            r_res_data  <= w_sum;
            r_res_id    <= w_winner;
            r_res_valid <= 1'b1;
            r_ptr       <= w_winner + 2'd1;
         end else if (w_consume) begin
            r_res_valid <= 1'b0;
         end
         if (w_consume && (r_served_cnt != 8'hFF))
            r_served_cnt <= r_served_cnt + 8'd1;
      end
   end

   assign bus.res_valid  = r_res_valid;
   assign bus.res_data   = r_res_data;
   assign bus.res_id     = r_res_id;
   assign bus.busy       = (r_state == HOLD);
   assign bus.served_cnt = r_served_cnt;
endmodule

// File: tb/tb_add_arbiter.sv
// Testbench for add_arbiter: a reference model checks every cycle, and directed scenarios check literal values.
module tb_add_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   add_arbiter_if bus();
   add_arbiter #(.N_REQ(4), .OFFSET(3'b111)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;
   bit check_en = 1'b0;

   // Reference state, held as plain integers.
   int  m_ptr   = 0;
   int  m_cnt   = 0;
   int  m_data  = 0;
   int  m_id    = 0;
   bit  m_valid = 1'b0;
   bit  m_busy  = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      int  w;
      int  exp_gnt;
      bit  opp;
      bit  consume;
      if (check_en) begin
         w = -1;
         opp = !m_busy || bus.res_ready;
         if (!rst && opp) begin
            for (int k = 0; k < 4; k++) begin
               int c;
               c = (m_ptr + k) % 4;
               if (w < 0 && bus.req[c]) w = c;
            end
         end
         exp_gnt = (w >= 0) ? (1 << w) : 0;
         chk("model_gnt",        int'(bus.gnt),        exp_gnt);
         chk("model_res_valid",  int'(bus.res_valid),  int'(m_valid));
         chk("model_res_data",   int'(bus.res_data),   m_data);
         chk("model_res_id",     int'(bus.res_id),     m_id);
         chk("model_busy",       int'(bus.busy),       int'(m_busy));
         chk("model_served_cnt", int'(bus.served_cnt), m_cnt);
         if (rst) begin
            m_ptr = 0; m_cnt = 0; m_data = 0; m_id = 0; m_valid = 0; m_busy = 0;
         end else begin
            consume = m_busy && m_valid && bus.res_ready;
            if (consume && m_cnt < 255) m_cnt++;
            if (w >= 0) begin
               m_data  = ((int'(bus.operand) >> (2 * w)) & 3) + 7;
               m_id    = w;
               m_valid = 1;
               m_busy  = 1;
               m_ptr   = (w + 1) % 4;
            end else if (consume) begin
               m_valid = 0;
               m_busy  = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      bus.req       = 4'b1111;
      bus.operand   = 8'h00;
      bus.res_ready = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      check_en = 1'b1;
      settle();
      // The requests are high during reset, so this also checks that reset blocks the grant.
      chk("reset_gnt",        int'(bus.gnt),        0);
      chk("reset_res_valid",  int'(bus.res_valid),  0);
      chk("reset_served_cnt", int'(bus.served_cnt), 0);
      chk("reset_busy",       int'(bus.busy),       0);
      tick();

      // Single request from requester 2 with operand 3.
      do_reset();
      bus.req = 4'b0100; bus.operand = 8'b0011_0000; bus.res_ready = 1'b1;
      settle();
      chk("single_gnt", int'(bus.gnt), 4);
      tick();
      bus.req = 4'b0000;
      settle();
      chk("single_valid", int'(bus.res_valid), 1);
      chk("single_data",  int'(bus.res_data),  10);
      chk("single_id",    int'(bus.res_id),    2);
      tick();
      settle();
      chk("single_cnt", int'(bus.served_cnt), 1);
      tick();

      // All four requesting back-to-back with zero operands.
      do_reset();
      bus.req = 4'b1111; bus.operand = 8'h00; bus.res_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("rr_gnt", int'(bus.gnt), 1 << (i % 4));
         if (i > 0) begin
            chk("rr_data", int'(bus.res_data), 7);
            chk("rr_busy", int'(bus.busy), 1);
         end
         tick();
      end

      // A pending result is held for five cycles with res_ready low.
      do_reset();
      bus.req = 4'b1111; bus.operand = 8'h00; bus.res_ready = 1'b0;
      settle();
      chk("bp_first_gnt", int'(bus.gnt), 1);
      tick();
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("bp_gnt",  int'(bus.gnt),        0);
         chk("bp_data", int'(bus.res_data),   7);
         chk("bp_id",   int'(bus.res_id),     0);
         chk("bp_cnt",  int'(bus.served_cnt), 0);
         tick();
      end
      bus.res_ready = 1'b1;
      settle();
      chk("bp_release_gnt", int'(bus.gnt), 2);
      tick();

      // The pointer wraps from requester 3 back to requester 0.
      do_reset();
      bus.req = 4'b1000; bus.res_ready = 1'b1;
      settle();
      chk("wrap_gnt3", int'(bus.gnt), 8);
      tick();
      bus.req = 4'b1001;
      settle();
      chk("wrap_gnt0", int'(bus.gnt), 1);
      tick();
      settle();
      chk("wrap_gnt3b", int'(bus.gnt), 8);
      tick();

      // A reset in HOLD drops the pending result without counting it.
      do_reset();
      bus.req = 4'b1111; bus.res_ready = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      chk("rstH_valid", int'(bus.res_valid),  0);
      chk("rstH_cnt",   int'(bus.served_cnt), 0);
      chk("rstH_gnt",   int'(bus.gnt),        1);
      tick();

      // Randomized traffic, including occasional resets.
      for (int i = 0; i < 2000; i++) begin
         rst           = ($urandom_range(0, 99) == 0);
         bus.req       = 4'($urandom);
         bus.operand   = 8'($urandom);
         bus.res_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      // The served count saturates.
      do_reset();
      bus.req = 4'b1111; bus.operand = 8'($urandom); bus.res_ready = 1'b1;
      for (int i = 0; i < 301; i++) tick();
      settle();
      chk("sat_cnt", int'(bus.served_cnt), 255);
      tick();
      tick();
      settle();
      chk("sat_hold", int'(bus.served_cnt), 255);
      tick();

      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
